// File: rtl/reg_bypass_pkg.sv
// rtl/reg_bypass_pkg.sv - shared defaults, limits and popcount helper for reg_bypass_pipe
package reg_bypass_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int DEPTH_DEF      = 4;
   localparam int DEPTH_MAX      = 8;
   localparam int CNT_MAX_W      = $clog2(DEPTH_MAX + 1);

   // Number of set bits in a stage mask, sized for the largest legal pipe
   function automatic logic [CNT_MAX_W-1:0] popcount(input logic [DEPTH_MAX-1:0] v);
      logic [CNT_MAX_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH_MAX; i++) begin
         n = n + CNT_MAX_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/reg_bypass_pipe_if.sv
// rtl/reg_bypass_pipe_if.sv - control/data bundle for reg_bypass_pipe (OCC present with REG_BYPASS_PIPE_OCC_EN)
interface reg_bypass_pipe_if #(
   parameter int DATA_WIDTH = reg_bypass_pkg::DATA_WIDTH_DEF,
   parameter int DEPTH      = reg_bypass_pkg::DEPTH_DEF
);
   localparam int LW = $clog2(DEPTH + 1);

   logic                  ENA;
   logic                  CLR;
   logic [DEPTH-1:0]      SELM;
   logic [DATA_WIDTH-1:0] D;
   logic                  D_VLD;
   logic [DATA_WIDTH-1:0] Q;
   logic                  Q_VLD;
   logic [LW-1:0]         LAT;
`ifdef REG_BYPASS_PIPE_OCC_EN
   logic [LW-1:0]         OCC;

   modport master (output ENA, CLR, SELM, D, D_VLD, input Q, Q_VLD, LAT, OCC);
   modport slave  (input ENA, CLR, SELM, D, D_VLD, output Q, Q_VLD, LAT, OCC);
`else
   modport master (output ENA, CLR, SELM, D, D_VLD, input Q, Q_VLD, LAT);
   modport slave  (input ENA, CLR, SELM, D, D_VLD, output Q, Q_VLD, LAT);
`endif
endinterface

// File: rtl/reg_bypass_pipe_stage.sv
// rtl/reg_bypass_pipe_stage.sv - one data+valid register with enable, clear and bypass mux
module reg_bypass_pipe_stage
   import reg_bypass_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ENA,
   input  logic                  CLR,
   input  logic                  SEL,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_vld,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld
);
   logic [DATA_WIDTH-1:0] data_q;
   logic                  vld_q;

   // Register loads on every enabled edge even when bypassed, so a later switch to registered shows the last load
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else if (CLR) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else if (ENA) begin
         data_q <= din;
         vld_q  <= din_vld;
      end
   end

   assign dout     = SEL ? data_q : din;
   assign dout_vld = SEL ? vld_q  : din_vld;

endmodule

// File: rtl/reg_bypass_pipe.sv
// rtl/reg_bypass_pipe.sv - chain of DEPTH selectable register/bypass stages; REG_BYPASS_PIPE_OCC_EN adds OCC
module reg_bypass_pipe
   import reg_bypass_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   reg_bypass_pipe_if.slave  bus
);
   localparam int LW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] chain_d [DEPTH+1];
   logic [DEPTH:0]        chain_v;
   logic [DEPTH_MAX-1:0]  sel_ext;

   assign chain_d[0] = bus.D;
   assign chain_v[0] = bus.D_VLD;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      reg_bypass_pipe_stage #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .CLK      (CLK),
         .RST      (RST),
         .ENA      (bus.ENA),
         .CLR      (bus.CLR),
         .SEL      (bus.SELM[i]),
         .din      (chain_d[i]),
         .din_vld  (chain_v[i]),
         .dout     (chain_d[i+1]),
         .dout_vld (chain_v[i+1])
      );
   end

   assign bus.Q     = chain_d[DEPTH];
   assign bus.Q_VLD = chain_v[DEPTH];

   assign sel_ext = DEPTH_MAX'(bus.SELM);
   assign bus.LAT = LW'(popcount(sel_ext));

`ifdef REG_BYPASS_PIPE_OCC_EN
   // A registered stage drives its own valid bit, so its output valid is the stored valid
   logic [DEPTH_MAX-1:0] occ_mask;
   assign occ_mask = DEPTH_MAX'(bus.SELM & chain_v[DEPTH:1]);
   assign bus.OCC  = LW'(popcount(occ_mask));
`endif

endmodule
